// File: rtl/axi_sram_rd_slv.sv
// -----------------------------------------------------------------------------
// axi_sram_rd_slv
//
// AXI4-Lite read-channel slave placed after the IFU/LSU read arbiter. It takes
// one AR request at a time and reads a synchronous single-port SRAM that has
// one cycle of read latency. It returns a single R beat with OKAY or SLVERR.
// Before each access it waits a configurable delay: a fixed part plus an
// optional LFSR-derived part. This gives the masters variable slave latency.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active low
//   ar_valid_i   AR valid from the arbiter
//   ar_addr_i    AR byte address
//   ar_ready_o   AR ready, high only in IDLE
//   r_valid_o    R valid, held until r_ready_i
//   r_data_o     R data (0 on SLVERR)
//   r_resp_o     R response: OKAY=2'b00, SLVERR=2'b10
//   r_ready_i    R ready from the arbiter
//   mem_req_o    SRAM read strobe (one cycle per OKAY access)
//   mem_addr_o   SRAM word index
//   mem_rdata_i  SRAM read data, valid the cycle after mem_req_o
// -----------------------------------------------------------------------------
module axi_sram_rd_slv #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                MEM_WORDS  = 32768,
    parameter int                BASE_DELAY = 0,
    parameter bit                RAND_EN    = 1'b0,
    parameter logic [3:0]        RAND_MASK  = 4'hF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ar_valid_i,
    input  logic [ADDR_W-1:0]            ar_addr_i,
    output logic                         ar_ready_o,
    output logic                         r_valid_o,
    output logic [DATA_W-1:0]            r_data_o,
    output logic [1:0]                   r_resp_o,
    input  logic                         r_ready_i,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [DATA_W-1:0]            mem_rdata_i
);

    localparam int              MEM_AW      = $clog2(MEM_WORDS);
    localparam longint unsigned SPAN        = 64'(MEM_WORDS) * 64'd4;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [15:0]     LFSR_SEED   = 16'hACE1;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        DELAY = 5'b00010,
        MEM   = 5'b00100,
        LATCH = 5'b01000,
        RESP  = 5'b10000
    } state_t;

    state_t              state_q;
    logic [4:0]          cnt_q;
    logic                err_q;
    logic [MEM_AW-1:0]   widx_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          resp_q;
    logic [15:0]         lfsr_q;

    logic [ADDR_W-1:0]   offset;
    logic                addr_err;
    logic [4:0]          d_load;
    logic                lfsr_fb;

    // Request decode: the address goes through one unsigned subtraction.
    // An address below BASE_ADDR wraps to a large offset, so a single upper
    // bound check covers both ends of the served window.
    always_comb begin
        offset   = ar_addr_i - BASE_ADDR;
        addr_err = (64'(offset) >= SPAN) || (ar_addr_i[1:0] != 2'b00);
        d_load   = 5'(BASE_DELAY) + (RAND_EN ? {1'b0, lfsr_q[3:0] & RAND_MASK} : 5'd0);
        // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
        lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    end

    // Control FSM plus the response registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            data_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
            unique case (state_q)
                IDLE: begin
                    if (ar_valid_i && ar_ready_o) begin
                        err_q  <= addr_err;
                        widx_q <= offset[MEM_AW+1:2];
                        cnt_q  <= d_load;
                        // The error beat is fully formed here; the SRAM is never touched.
                        if (addr_err) begin
                            data_q <= '0;
                            resp_q <= RESP_SLVERR;
                        end
                        if (d_load != 5'd0)
                            state_q <= DELAY;
                        else if (addr_err)
                            state_q <= RESP;
                        else
                            state_q <= MEM;
                    end
                end
                DELAY: begin
                    // Leaving when the counter reads 1 gives exactly d cycles here.
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1)
                        state_q <= err_q ? RESP : MEM;
                end
                MEM: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    data_q  <= mem_rdata_i;
                    resp_q  <= RESP_OKAY;
                    state_q <= RESP;
                end
                RESP: begin
                    if (r_ready_i)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state. The rst_i term forces them all
    // low while reset is held, even before the first reset edge.
    assign ar_ready_o = rst_i && (state_q == IDLE);
    assign r_valid_o  = rst_i && (state_q == RESP);
    assign r_data_o   = rst_i ? data_q : '0;
    assign r_resp_o   = rst_i ? resp_q : RESP_OKAY;
    assign mem_req_o  = rst_i && (state_q == MEM);
    assign mem_addr_o = (rst_i && (state_q == MEM)) ? widx_q : '0;

endmodule

// File: tb/tb_axi_sram_rd_slv.sv
// Directed bench for axi_sram_rd_slv. It builds three instances that differ
// only in their delay settings:
//   0: no delay   1: BASE_DELAY=3   2: BASE_DELAY=3 plus random delay with mask 7
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
// Cycle 1 is the first falling edge after the AR handshake edge.
module tb_axi_sram_rd_slv;
    localparam int          MEM_WORDS = 32768;
    localparam int          AW        = 15;
    localparam int          NDUT      = 3;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          ar_valid  [NDUT];
    logic [31:0]   ar_addr   [NDUT];
    logic          ar_ready  [NDUT];
    logic          r_valid   [NDUT];
    logic [31:0]   r_data    [NDUT];
    logic [1:0]    r_resp    [NDUT];
    logic          r_ready   [NDUT];
    logic          mem_req   [NDUT];
    logic [AW-1:0] mem_addr  [NDUT];

    logic [31:0] mem [MEM_WORDS];
    int beats [NDUT];
    int mreqs [NDUT];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [31:0] rdata;
        axi_sram_rd_slv #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .BASE_ADDR (BASE),
            .MEM_WORDS (MEM_WORDS),
            .BASE_DELAY((g == 0) ? 0 : 3),
            .RAND_EN   (g == 2),
            .RAND_MASK ((g == 2) ? 4'h7 : 4'hF)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .ar_valid_i (ar_valid[g]),
            .ar_addr_i  (ar_addr[g]),
            .ar_ready_o (ar_ready[g]),
            .r_valid_o  (r_valid[g]),
            .r_data_o   (r_data[g]),
            .r_resp_o   (r_resp[g]),
            .r_ready_i  (r_ready[g]),
            .mem_req_o  (mem_req[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_rdata_i(rdata)
        );
        // SRAM model: the output is garbage unless a read was strobed the cycle before.
        always @(posedge clk) rdata <= mem_req[g] ? mem[mem_addr[g]] : $urandom;
    end

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (r_valid[g] === 1'b1 && r_ready[g] === 1'b1) beats[g] <= beats[g] + 1;
            if (mem_req[g] === 1'b1) mreqs[g] <= mreqs[g] + 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of the last rd() call
    int          wait_o, lat_o, stable_o, mreq_o, mcyc_o, maddr_o, beat_o;
    logic [31:0] data_o;
    logic [1:0]  resp_o;
    logic        busy_rdy_o;

    // One read on instance g. R stays stalled for 'stall' cycles after r_valid rises.
    task automatic rd(input int g, input logic [31:0] a, input int stall);
        int b0, m0;
        b0 = beats[g];
        m0 = mreqs[g];
        ar_valid[g] = 1'b1;
        ar_addr[g]  = a;
        r_ready[g]  = 1'b0;
        wait_o = 0;
        while (ar_ready[g] !== 1'b1 && wait_o < 50) begin
            @(negedge clk);
            wait_o++;
        end
        @(negedge clk);
        ar_valid[g] = 1'b0;
        ar_addr[g]  = '0;
        lat_o = 1; mcyc_o = -1; maddr_o = -1; busy_rdy_o = 1'b0;
        while (r_valid[g] !== 1'b1 && lat_o < 40) begin
            if (mem_req[g] === 1'b1) begin
                mcyc_o  = lat_o;
                maddr_o = int'(mem_addr[g]);
            end
            if (ar_ready[g] !== 1'b0) busy_rdy_o = 1'b1;
            @(negedge clk);
            lat_o++;
        end
        data_o = r_data[g];
        resp_o = r_resp[g];
        stable_o = 0;
        for (int i = 0; i <= stall; i++) begin
            if (r_valid[g] === 1'b1 && r_data[g] === data_o && r_resp[g] === resp_o) stable_o++;
            if (ar_ready[g] !== 1'b0) busy_rdy_o = 1'b1;
            if (i < stall) @(negedge clk);
        end
        r_ready[g] = 1'b1;
        @(negedge clk);
        r_ready[g] = 1'b0;
        mreq_o = mreqs[g] - m0;
        beat_o = beats[g] - b0;
    endtask

    initial begin
        logic [31:0] err_addr [3];
        int b0, m0, vis;
        int seen, range_bad, data_bad, idx;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
        mem[5] = 32'hDEAD_BEEF;
        for (int g = 0; g < NDUT; g++) begin
            ar_valid[g] = 1'b0; ar_addr[g] = '0; r_ready[g] = 1'b0;
        end

        // ---- reset: 3 cycles with a pending AR, all outputs low ----
        rst = 1'b0;
        ar_valid[0] = 1'b1;
        ar_addr[0]  = BASE + 32'h4;
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++)
                chk("rst_outputs_zero",
                    {ar_ready[g], r_valid[g], mem_req[g], mem_addr[g], r_data[g], r_resp[g]}, '0);
        end
        rst = 1'b1;
        ar_valid[0] = 1'b0;
        @(negedge clk);
        chk("rel_ar_ready", ar_ready[0], 1'b1);
        chk("rel_no_mem_req", mreqs[0], 0);

        // ---- single read, d=0 ----
        rd(0, BASE + 32'h14, 0);
        chk("rd_wait",      wait_o, 0);
        chk("rd_latency",   lat_o, 3);
        chk("rd_data",      data_o, 32'hDEAD_BEEF);
        chk("rd_resp",      resp_o, 2'b00);
        chk("rd_mreq_cnt",  mreq_o, 1);
        chk("rd_mreq_cyc",  mcyc_o, 1);
        chk("rd_mem_addr",  maddr_o, 5);
        chk("rd_beats",     beat_o, 1);
        chk("rd_busy_rdy",  busy_rdy_o, 1'b0);
        chk("rd_ar_ready4", ar_ready[0], 1'b1);

        // ---- back-to-back: issued in cycle 4 of the previous read ----
        rd(0, BASE + 32'd400, 0);
        chk("b2b_wait",    wait_o, 0);
        chk("b2b_latency", lat_o, 3);
        chk("b2b_data",    data_o, mem[100]);
        chk("b2b_addr",    maddr_o, 100);

        // ---- backpressure: r_ready low for 6 cycles ----
        rd(0, BASE + 32'h14, 6);
        chk("bp_latency",  lat_o, 3);
        chk("bp_stable",   stable_o, 7);
        chk("bp_data",     data_o, 32'hDEAD_BEEF);
        chk("bp_busy_rdy", busy_rdy_o, 1'b0);
        chk("bp_beats",    beat_o, 1);
        chk("bp_ready",    ar_ready[0], 1'b1);

        // ---- error addresses ----
        err_addr[0] = 32'h7FFF_FFFC;
        err_addr[1] = 32'h8000_0002;
        err_addr[2] = BASE + 32'(4 * MEM_WORDS);
        for (int k = 0; k < 3; k++) begin
            rd(0, err_addr[k], 0);
            chk("err_latency", lat_o, 1);
            chk("err_resp",    resp_o, 2'b10);
            chk("err_data",    data_o, 32'h0);
            chk("err_no_mreq", mreq_o, 0);
            chk("err_beats",   beat_o, 1);
        end

        // ---- last word in range ----
        rd(0, BASE + 32'(4 * MEM_WORDS - 4), 0);
        chk("top_resp", resp_o, 2'b00);
        chk("top_data", data_o, mem[MEM_WORDS-1]);
        chk("top_addr", maddr_o, MEM_WORDS - 1);

        // ---- fixed delay of 3 ----
        rd(1, BASE + 32'h14, 0);
        chk("dly_latency", lat_o, 6);
        chk("dly_data",    data_o, 32'hDEAD_BEEF);
        chk("dly_mreq_cyc", mcyc_o, 4);

        // ---- random delay: latency 6..13, every value seen, data correct ----
        seen = 0; range_bad = 0; data_bad = 0;
        for (int n = 0; n < 1000; n++) begin
            idx = int'($urandom_range(MEM_WORDS - 1, 0));
            rd(2, BASE + 32'(4 * idx), 0);
            if (lat_o < 6 || lat_o > 13) range_bad++;
            else seen = seen | (1 << (lat_o - 6));
            if (data_o !== mem[idx] || resp_o !== 2'b00) data_bad++;
        end
        chk("rnd_lat_range", range_bad, 0);
        chk("rnd_lat_seen",  seen, 8'hFF);
        chk("rnd_data",      data_bad, 0);

        // ---- reset while in DELAY ----
        b0 = beats[1]; m0 = mreqs[1];
        ar_valid[1] = 1'b1;
        ar_addr[1]  = BASE + 32'h14;
        @(negedge clk);
        ar_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrd_rst_valid", r_valid[1], 1'b0);
        rst = 1'b1;
        r_ready[1] = 1'b1;
        vis = 0;
        repeat (8) begin
            @(negedge clk);
            if (r_valid[1] !== 1'b0) vis++;
        end
        r_ready[1] = 1'b0;
        chk("mrd_no_valid", vis, 0);
        chk("mrd_no_beat",  beats[1] - b0, 0);
        chk("mrd_no_mreq",  mreqs[1] - m0, 0);
        rd(1, BASE + 32'd28, 0);
        chk("mrd_after_lat",  lat_o, 6);
        chk("mrd_after_data", data_o, mem[7]);

        // ---- reset while in RESP ----
        b0 = beats[0];
        ar_valid[0] = 1'b1;
        ar_addr[0]  = BASE + 32'h14;
        @(negedge clk);
        ar_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrr_in_resp", r_valid[0], 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrr_rst_valid", r_valid[0], 1'b0);
        rst = 1'b1;
        r_ready[0] = 1'b1;
        vis = 0;
        repeat (6) begin
            @(negedge clk);
            if (r_valid[0] !== 1'b0) vis++;
        end
        r_ready[0] = 1'b0;
        chk("mrr_no_valid", vis, 0);
        chk("mrr_no_beat",  beats[0] - b0, 0);
        rd(0, BASE + 32'd36, 0);
        chk("mrr_after_lat",  lat_o, 3);
        chk("mrr_after_data", data_o, mem[9]);
        chk("mrr_after_resp", resp_o, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
